// File: rtl/mont_modexp_ctrl_if.sv
// rtl/mont_modexp_ctrl_if.sv - pulse-start/pulse-done bus to a shared Montgomery multiplier
interface mont_modexp_ctrl_if #(
    parameter int NBITS = 256
);
    logic             mm_enable_p;
    logic [NBITS-1:0] mm_a;
    logic [NBITS-1:0] mm_b;
    logic [NBITS-1:0] mm_m;
    logic [11:0]      mm_m_size;
    logic [NBITS-1:0] mm_y;
    logic             mm_done_p;

    modport master (
        output mm_enable_p, mm_a, mm_b, mm_m, mm_m_size,
        input  mm_y, mm_done_p
    );

    modport slave (
        input  mm_enable_p, mm_a, mm_b, mm_m, mm_m_size,
        output mm_y, mm_done_p
    );
endinterface

// File: rtl/mont_modexp_ctrl.sv
// rtl/mont_modexp_ctrl.sv - left-to-right square-and-multiply modexp sequencer over a Montgomery multiplier
// Define MODEXP_SKIP_LZ_EN to skip leading zero exponent bits without multiplier ops.
module mont_modexp_ctrl #(
    parameter int NBITS = 256,
    parameter int EBITS = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_p,
    input  logic [NBITS-1:0] base,
    input  logic [EBITS-1:0] exponent,
    input  logic [11:0]      exp_size,
    input  logic [NBITS-1:0] modulus,
    input  logic [11:0]      m_size,
    input  logic [NBITS-1:0] r2_mod,
    output logic             busy,
    output logic [NBITS-1:0] result,
    output logic             done_p,
    output logic             err,
    output logic [15:0]      mul_count,
    mont_modexp_ctrl_if.master mm
);
    localparam int EIW = (EBITS > 1) ? $clog2(EBITS) : 1;
    localparam logic [NBITS-1:0] ONE = {{(NBITS-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        ST_IDLE, ST_REJECT, ST_TO_X, ST_TO_ONE, ST_SKIP, ST_SQR, ST_MUL, ST_FROM, ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             wait_q, wait_d;
    logic             bit_dec;
    logic [NBITS-1:0] base_q, mod_q, r2_q, x_q, acc_q;
    logic [EBITS-1:0] exp_q;
    logic [11:0]      esize_q, msize_q, bit_idx_q;
    logic             params_ok, cur_bit, last_bit, is_op;

    assign params_ok = modulus[0] && (m_size != 12'd0) && (m_size <= 12'(NBITS)) &&
                       (exp_size <= 12'(EBITS));
    assign cur_bit   = (bit_idx_q < 12'(EBITS)) ? exp_q[bit_idx_q[EIW-1:0]] : 1'b0;
    assign last_bit  = (bit_idx_q == 12'd0);
    assign is_op     = (state_q == ST_TO_X) || (state_q == ST_TO_ONE) || (state_q == ST_SQR) ||
                       (state_q == ST_MUL)  || (state_q == ST_FROM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            wait_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        bit_dec = 1'b0;
        case (state_q)
            ST_IDLE: if (start_p) state_d = params_ok ? ST_TO_X : ST_REJECT;
            ST_REJECT, ST_DONE: state_d = ST_IDLE;
            ST_TO_X, ST_TO_ONE, ST_SQR, ST_MUL, ST_FROM: begin
                if (!wait_q) begin
                    wait_d = 1'b1;
                end else if (mm.mm_done_p) begin
                    wait_d = 1'b0;
                    case (state_q)
                        ST_TO_X: state_d = ST_TO_ONE;
                        ST_TO_ONE: begin
                            if (esize_q == 12'd0) state_d = ST_FROM;
`ifdef MODEXP_SKIP_LZ_EN
                            else state_d = ST_SKIP;
`else
                            else state_d = ST_SQR;
`endif
                        end
                        ST_SQR: begin
                            if (cur_bit)       state_d = ST_MUL;
                            else if (last_bit) state_d = ST_FROM;
                            else               bit_dec = 1'b1;
                        end
                        ST_MUL: begin
                            if (last_bit) state_d = ST_FROM;
                            else begin
                                state_d = ST_SQR;
                                bit_dec = 1'b1;
                            end
                        end
                        default: state_d = ST_DONE;
                    endcase
                end
            end
`ifdef MODEXP_SKIP_LZ_EN
            // acc = R (Montgomery one) here, so squaring it is a no-op worth skipping
            ST_SKIP: begin
                if (cur_bit)       state_d = ST_SQR;
                else if (last_bit) state_d = ST_FROM;
                else               bit_dec = 1'b1;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy           = is_op || (state_q == ST_SKIP);
        done_p         = (state_q == ST_REJECT) || (state_q == ST_DONE);
        err            = (state_q == ST_REJECT);
        mm.mm_enable_p = is_op && !wait_q;
        mm.mm_m        = mod_q;
        mm.mm_m_size   = msize_q;
        mm.mm_a        = '0;
        mm.mm_b        = '0;
        case (state_q)
            ST_TO_X:   begin mm.mm_a = base_q; mm.mm_b = r2_q;  end
            ST_TO_ONE: begin mm.mm_a = ONE;    mm.mm_b = r2_q;  end
            ST_SQR:    begin mm.mm_a = acc_q;  mm.mm_b = acc_q; end
            ST_MUL:    begin mm.mm_a = acc_q;  mm.mm_b = x_q;   end
            ST_FROM:   begin mm.mm_a = acc_q;  mm.mm_b = ONE;   end
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q    <= '0;
            exp_q     <= '0;
            esize_q   <= '0;
            mod_q     <= '0;
            msize_q   <= '0;
            r2_q      <= '0;
            x_q       <= '0;
            acc_q     <= '0;
            bit_idx_q <= '0;
            mul_count <= '0;
            result    <= '0;
        end else if (state_q == ST_IDLE && start_p) begin
            base_q    <= base;
            exp_q     <= exponent;
            esize_q   <= exp_size;
            mod_q     <= modulus;
            msize_q   <= m_size;
            r2_q      <= r2_mod;
            bit_idx_q <= exp_size - 12'd1;
            mul_count <= '0;
        end else begin
            if (is_op && !wait_q) mul_count <= mul_count + 16'd1;
            if (wait_q && mm.mm_done_p) begin
                case (state_q)
                    ST_TO_X: x_q    <= mm.mm_y;
                    ST_FROM: result <= mm.mm_y;
                    default: acc_q  <= mm.mm_y;
                endcase
            end
            if (bit_dec) bit_idx_q <= bit_idx_q - 12'd1;
        end
    end
endmodule
